// File: rtl/imul_prod_accum.sv
// -----------------------------------------------------------------------------
// imul_prod_accum
//
// Dot-product reduction stage that sits behind the fixed-latency integer
// multiplier. A length descriptor arrives on the cfg interface. The block then
// accepts that many products from the multiplier response stream, adds them
// into a running sum (modulo 2^NBITS), and emits one result per vector.
//
// All outputs are decoded from registered state only (Moore). No *_val or
// *_rdy input reaches an output combinationally.
//
// Ports
//   clk      in   1          clock
//   reset    in   1          synchronous, active-high reset
//   cfg_val  in   1          length descriptor valid
//   cfg_rdy  out  1          ready to accept a length descriptor (IDLE)
//   cfg_msg  in   LEN_NBITS  number of products in the next vector
//   in_val   in   1          product valid (multiplier resp_val)
//   in_rdy   out  1          ready for a product (multiplier resp_rdy)
//   in_msg   in   NBITS      product (multiplier resp_msg)
//   out_val  out  1          accumulated sum valid (DONE)
//   out_rdy  in   1          downstream ready
//   out_msg  out  NBITS      accumulated sum (the sum register in every state)
//   busy     out  1          high in any state other than IDLE
// -----------------------------------------------------------------------------
module imul_prod_accum #(
  parameter int NBITS     = 32,
  parameter int LEN_NBITS = 8
) (
  input  logic                 clk,
  input  logic                 reset,

  input  logic                 cfg_val,
  output logic                 cfg_rdy,
  input  logic [LEN_NBITS-1:0] cfg_msg,

  input  logic                 in_val,
  output logic                 in_rdy,
  input  logic [NBITS-1:0]     in_msg,

  output logic                 out_val,
  input  logic                 out_rdy,
  output logic [NBITS-1:0]     out_msg,

  output logic                 busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_next;
  logic [NBITS-1:0]       r_sum;
  logic [NBITS-1:0]       w_sum_next;
  // The remaining count is loaded from cfg_msg and only ever decremented while
  // non-zero, so LEN_NBITS bits cover the maximum length without wrapping.
  logic [LEN_NBITS-1:0]   r_remaining;
  logic [LEN_NBITS-1:0]   w_remaining_next;

  logic                   w_cfg_xfer;
  logic                   w_in_xfer;
  logic                   w_out_xfer;

  // ---------------------------------------------------------------------------
  // Moore output decode
  // ---------------------------------------------------------------------------
  assign cfg_rdy = (r_state == ST_IDLE);
  assign in_rdy  = (r_state == ST_ACC);
  assign out_val = (r_state == ST_DONE);
  assign out_msg = r_sum;
  assign busy    = (r_state != ST_IDLE);

  assign w_cfg_xfer = cfg_val & cfg_rdy;
  assign w_in_xfer  = in_val  & in_rdy;
  assign w_out_xfer = out_val & out_rdy;

  // ---------------------------------------------------------------------------
  // Next-state and datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a hold value before the case so that no path
    // leaves it unassigned; otherwise synthesis infers a latch.
    w_state_next     = r_state;
    w_sum_next       = r_sum;
    w_remaining_next = r_remaining;

    case (r_state)
      ST_IDLE: begin
        if (w_cfg_xfer) begin
          w_sum_next       = '0;
          w_remaining_next = cfg_msg;
          // A zero-length vector goes straight to DONE with a zero result.
          w_state_next     = (cfg_msg == '0) ? ST_DONE : ST_ACC;
        end
      end

      ST_ACC: begin
        if (w_in_xfer) begin
          // Unsigned add; the carry out of the top bit is dropped.
          w_sum_next       = r_sum + in_msg;
          w_remaining_next = r_remaining - LEN_NBITS'(1);
          if (r_remaining == LEN_NBITS'(1)) begin
            w_state_next = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        // The sum is held after the handshake; the next cfg transfer clears it.
        if (w_out_xfer) begin
          w_state_next = ST_IDLE;
        end
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      // Reset drops any partial vector: sum and count are cleared with the
      // state, so nothing stale can reach out_msg afterwards.
      r_state     <= ST_IDLE;
      r_sum       <= '0;
      r_remaining <= '0;
    end else begin
      r_state     <= w_state_next;
      r_sum       <= w_sum_next;
      r_remaining <= w_remaining_next;
    end
  end

endmodule

// File: tb/tb_imul_prod_accum.sv
// -----------------------------------------------------------------------------
// tb_imul_prod_accum
//
// Directed bench for imul_prod_accum. Inputs change and outputs are sampled
// on the falling clock edge, half a cycle away from the active rising edge.
// A table of vectors (length, products, gaps, expected sum) runs in a loop.
// Hand-written sequences then cover backpressure, mid-vector reset and the
// maximum vector length.
// -----------------------------------------------------------------------------
module tb_imul_prod_accum;

  localparam int NBITS     = 32;
  localparam int LEN_NBITS = 8;
  localparam int MAXP      = 5;
  localparam int NV        = 7;
  localparam int WAIT_MAX  = 50;

  logic                 clk;
  logic                 reset;
  logic                 cfg_val;
  logic                 cfg_rdy;
  logic [LEN_NBITS-1:0] cfg_msg;
  logic                 in_val;
  logic                 in_rdy;
  logic [NBITS-1:0]     in_msg;
  logic                 out_val;
  logic                 out_rdy;
  logic [NBITS-1:0]     out_msg;
  logic                 busy;

  int checks = 0;
  int errors = 0;

  imul_prod_accum #(
    .NBITS     (NBITS),
    .LEN_NBITS (LEN_NBITS)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .cfg_val (cfg_val),
    .cfg_rdy (cfg_rdy),
    .cfg_msg (cfg_msg),
    .in_val  (in_val),
    .in_rdy  (in_rdy),
    .in_msg  (in_msg),
    .out_val (out_val),
    .out_rdy (out_rdy),
    .out_msg (out_msg),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [LEN_NBITS-1:0]        len;
    logic [MAXP-1:0][NBITS-1:0]  p;
    logic [MAXP-1:0][3:0]        gap;
    logic [NBITS-1:0]            exp;
  } vec_t;

  vec_t vec [NV];

  task automatic check(input string name, input logic [NBITS-1:0] act,
                       input logic [NBITS-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Present a descriptor and hold it until it is taken.
  task automatic do_cfg(input logic [LEN_NBITS-1:0] len);
    int n;
    n = 0;
    cfg_val = 1'b1;
    cfg_msg = len;
    while (!cfg_rdy && n < WAIT_MAX) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!cfg_rdy) begin
      errors++;
      $display("FAIL cfg_timeout: got cfg_rdy=0 expected 1 within %0d cycles", WAIT_MAX);
    end
    @(negedge clk);
    cfg_val = 1'b0;
  endtask

  // Idle for 'gap' cycles, then present one product and hold it until taken.
  task automatic do_product(input logic [NBITS-1:0] p, input int gap);
    int n;
    in_val = 1'b0;
    for (int g = 0; g < gap; g++) @(negedge clk);
    n = 0;
    in_val = 1'b1;
    in_msg = p;
    while (!in_rdy && n < WAIT_MAX) begin
      @(negedge clk);
      n++;
    end
    if (!in_rdy) begin
      checks++;
      errors++;
      $display("FAIL in_timeout: got in_rdy=0 expected 1 within %0d cycles", WAIT_MAX);
    end
    @(negedge clk);
    in_val = 1'b0;
  endtask

  // The result must already be valid on the sample point after the final
  // transfer. Take it and confirm the return to IDLE one cycle later.
  task automatic take_result(input string name, input logic [NBITS-1:0] exp);
    check({name, "_latency_out_val"}, {31'd0, out_val}, 32'd1);
    check({name, "_out_msg"}, out_msg, exp);
    check({name, "_in_rdy_done"}, {31'd0, in_rdy}, 32'd0);
    out_rdy = 1'b1;
    @(negedge clk);
    out_rdy = 1'b0;
    check({name, "_idle_cfg_rdy"}, {31'd0, cfg_rdy}, 32'd1);
    check({name, "_idle_out_val"}, {31'd0, out_val}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000 time units");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // -------------------------------------------------------------------------
    // Vector table
    // -------------------------------------------------------------------------
    for (int i = 0; i < NV; i++) vec[i] = '0;
    // basic: 2 + 5 + 7
    vec[0].len = 8'd3;
    vec[0].p[0] = 32'd2; vec[0].p[1] = 32'd5; vec[0].p[2] = 32'd7;
    vec[0].exp = 32'd14;
    // two zero-length vectors back to back
    vec[1].len = 8'd0; vec[1].exp = 32'd0;
    vec[2].len = 8'd0; vec[2].exp = 32'd0;
    // overflow wraps modulo 2^32
    vec[3].len = 8'd2;
    vec[3].p[0] = 32'hFFFF_FFFF; vec[3].p[1] = 32'h0000_0003;
    vec[3].exp = 32'h0000_0002;
    // bubbles between products: 1 + 2 + 3 + 4
    vec[4].len = 8'd4;
    vec[4].p[0] = 32'd1; vec[4].p[1] = 32'd2; vec[4].p[2] = 32'd3; vec[4].p[3] = 32'd4;
    vec[4].gap[0] = 4'd2; vec[4].gap[1] = 4'd1; vec[4].gap[3] = 4'd3;
    vec[4].exp = 32'd10;
    // multiplier responses for (3,4) and (5,6): 12 + 30
    vec[5].len = 8'd2;
    vec[5].p[0] = 32'd12; vec[5].p[1] = 32'd30;
    vec[5].exp = 32'd42;
    // five-product vector with large operands
    vec[6].len = 8'd5;
    vec[6].p[0] = 32'h8000_0000; vec[6].p[1] = 32'h4000_0000; vec[6].p[2] = 32'h2000_0000;
    vec[6].p[3] = 32'h1000_0000; vec[6].p[4] = 32'h1000_0001;
    vec[6].gap[2] = 4'd1;
    vec[6].exp = 32'h0000_0001;

    reset   = 1'b1;
    cfg_val = 1'b0;
    cfg_msg = '0;
    in_val  = 1'b0;
    in_msg  = '0;
    out_rdy = 1'b0;

    // -------------------------------------------------------------------------
    // Reset state
    // -------------------------------------------------------------------------
    @(negedge clk);
    @(negedge clk);
    check("rst_cfg_rdy", {31'd0, cfg_rdy}, 32'd1);
    check("rst_in_rdy",  {31'd0, in_rdy},  32'd0);
    check("rst_out_val", {31'd0, out_val}, 32'd0);
    check("rst_out_msg", out_msg,          32'd0);
    check("rst_busy",    {31'd0, busy},    32'd0);
    reset = 1'b0;
    @(negedge clk);

    // -------------------------------------------------------------------------
    // Table-driven vectors
    // -------------------------------------------------------------------------
    for (int v = 0; v < NV; v++) begin
      do_cfg(vec[v].len);
      if (vec[v].len == '0) begin
        check($sformatf("vec%0d_zero_in_rdy", v), {31'd0, in_rdy}, 32'd0);
      end else begin
        check($sformatf("vec%0d_acc_busy", v), {31'd0, busy}, 32'd1);
      end
      for (int k = 0; k < int'(vec[v].len); k++) begin
        do_product(vec[v].p[k], int'(vec[v].gap[k]));
      end
      take_result($sformatf("vec%0d", v), vec[v].exp);
    end

    // -------------------------------------------------------------------------
    // Backpressure: random bubbles, then out_rdy held low for 5 cycles while a
    // product is being offered that must not be consumed.
    // -------------------------------------------------------------------------
    do_cfg(8'd4);
    for (int k = 1; k <= 4; k++) do_product(NBITS'(k), int'($urandom_range(0, 3)));
    check("bp_out_val", {31'd0, out_val}, 32'd1);
    check("bp_out_msg", out_msg, 32'd10);
    in_val = 1'b1;
    in_msg = 32'd99;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("bp_hold%0d_out_val", c), {31'd0, out_val}, 32'd1);
      check($sformatf("bp_hold%0d_out_msg", c), out_msg, 32'd10);
      check($sformatf("bp_hold%0d_cfg_rdy", c), {31'd0, cfg_rdy}, 32'd0);
      check($sformatf("bp_hold%0d_in_rdy", c),  {31'd0, in_rdy},  32'd0);
    end
    in_val  = 1'b0;
    out_rdy = 1'b1;
    @(negedge clk);
    out_rdy = 1'b0;
    check("bp_release_cfg_rdy", {31'd0, cfg_rdy}, 32'd1);
    check("bp_release_out_val", {31'd0, out_val}, 32'd0);
    check("bp_release_out_msg_held", out_msg, 32'd10);

    // -------------------------------------------------------------------------
    // Mid-vector reset
    // -------------------------------------------------------------------------
    do_cfg(8'd5);
    do_product(32'd10, 0);
    do_product(32'd20, 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mrst_cfg_rdy", {31'd0, cfg_rdy}, 32'd1);
    check("mrst_in_rdy",  {31'd0, in_rdy},  32'd0);
    check("mrst_out_val", {31'd0, out_val}, 32'd0);
    check("mrst_busy",    {31'd0, busy},    32'd0);
    check("mrst_out_msg", out_msg,          32'd0);
    do_cfg(8'd1);
    do_product(32'd9, 0);
    take_result("mrst_after", 32'd9);

    // -------------------------------------------------------------------------
    // Maximum length (255) with no counter wrap
    // -------------------------------------------------------------------------
    do_cfg(8'd255);
    for (int k = 0; k < 254; k++) do_product(32'd1, 0);
    check("max_not_early_out_val", {31'd0, out_val}, 32'd0);
    check("max_not_early_in_rdy",  {31'd0, in_rdy},  32'd1);
    do_product(32'd1, 0);
    take_result("max", 32'd255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
